// File: rtl/umai_mem_responder.sv
// UMAI slave-side responder: terminates wcmd/rcmd/wdata/rdata into a flop-based 512-bit scratchpad.
// Optional backpressure stress (LFSR-driven stalls) enabled by defining UMAI_RESP_STALL_EN.
module umai_mem_responder #(
  parameter int unsigned Depth = 64
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_wcmd_valid,
  output logic         o_wcmd_ready,
  input  logic [31:0]  i_wcmd_addr,
  input  logic [5:0]   i_wcmd_len,
  input  logic         i_rcmd_valid,
  output logic         o_rcmd_ready,
  input  logic [31:0]  i_rcmd_addr,
  input  logic [5:0]   i_rcmd_len,
  input  logic         i_wvalid,
  output logic         o_wready,
  input  logic [511:0] i_wdata,
  output logic         o_rvalid,
  input  logic         i_rready,
  output logic [511:0] o_rdata
);

  localparam int unsigned DataW = 512;
  localparam int unsigned IdxW  = $clog2(Depth);
  localparam int unsigned CntW  = 7;
  localparam logic        PrioWr = 1'b0;
  localparam logic        PrioRd = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2
  } state_e;

  state_e            state;
  state_e            state_nxt;
  logic              prio;
  logic [IdxW-1:0]   ptr;
  logic [CntW-1:0]   cnt;
  logic [DataW-1:0]  mem [Depth];
  logic              stall;

  logic              wcmd_fire;
  logic              rcmd_fire;
  logic              wfire;
  logic              rfire;
  logic              last_beat;
  logic [IdxW-1:0]   widx;
  logic [IdxW-1:0]   ridx;
  logic              unused_addr;

  assign widx      = i_wcmd_addr[6 +: IdxW];
  assign ridx      = i_rcmd_addr[6 +: IdxW];
  assign wcmd_fire = i_wcmd_valid & o_wcmd_ready;
  assign rcmd_fire = i_rcmd_valid & o_rcmd_ready;
  assign wfire     = i_wvalid & o_wready;
  assign rfire     = o_rvalid & i_rready;
  assign last_beat = (cnt == CntW'(1));

  // Byte-offset bits and bits above the word index are don't-care.
  assign unused_addr = ^{i_wcmd_addr, i_rcmd_addr};

`ifdef UMAI_RESP_STALL_EN
  // x^8+x^6+x^5+x^4+1 Fibonacci LFSR; bit 0 injects a stall cycle.
  logic [7:0] lfsr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lfsr <= 8'hA5;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign stall = lfsr[0];
`else
  assign stall = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (wcmd_fire) begin
          state_nxt = S_WRITE;
        end else if (rcmd_fire) begin
          state_nxt = S_READ;
        end
      end
      S_WRITE: begin
        if (wfire && last_beat) begin
          state_nxt = S_IDLE;
        end
      end
      S_READ: begin
        if (rfire && last_beat) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs; command readys are held low while reset is asserted.
  always_comb begin
    o_wcmd_ready = 1'b0;
    o_rcmd_ready = 1'b0;
    o_wready     = 1'b0;
    case (state)
      S_IDLE: begin
        o_wcmd_ready = i_rst_n & ~stall & i_wcmd_valid & (~i_rcmd_valid | (prio == PrioWr));
        o_rcmd_ready = i_rst_n & ~stall & i_rcmd_valid & (~i_wcmd_valid | (prio == PrioRd));
      end
      S_WRITE: o_wready = ~stall;
      default: ;
    endcase
  end

  // Grant alternation: after any acceptance the other command type wins the next tie.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prio <= PrioWr;
    end else if (wcmd_fire) begin
      prio <= PrioRd;
    end else if (rcmd_fire) begin
      prio <= PrioWr;
    end
  end

  // Burst pointer, beat counter and read data register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr      <= '0;
      cnt      <= '0;
      o_rvalid <= 1'b0;
      o_rdata  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (wcmd_fire) begin
            ptr <= widx;
            cnt <= CntW'(i_wcmd_len) + CntW'(1);
          end else if (rcmd_fire) begin
            o_rdata  <= mem[ridx];
            o_rvalid <= 1'b1;
            ptr      <= ridx + IdxW'(1);
            cnt      <= CntW'(i_rcmd_len) + CntW'(1);
          end
        end
        S_WRITE: begin
          if (wfire) begin
            ptr <= ptr + IdxW'(1);
            cnt <= cnt - CntW'(1);
          end
        end
        S_READ: begin
          if (rfire) begin
            cnt <= cnt - CntW'(1);
            if (!last_beat && !stall) begin
              o_rdata  <= mem[ptr];
              o_rvalid <= 1'b1;
              ptr      <= ptr + IdxW'(1);
            end else begin
              o_rvalid <= 1'b0;
            end
          end else if (!o_rvalid && !stall) begin
            // Refill after a stalled reload.
            o_rdata  <= mem[ptr];
            o_rvalid <= 1'b1;
            ptr      <= ptr + IdxW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Scratchpad storage; intentionally not reset so contents survive a mid-burst reset.
  always_ff @(posedge i_clk) begin
    if (wfire) begin
      mem[ptr] <= i_wdata;
    end
  end

endmodule
